// File: rtl/blocking_port_peer.sv
`default_nettype none
// ============================================================================
//  Module   : blocking_port_peer
//  Brief    : Peer endpoint for blocking-port handshake channels. Drives the
//             consumer side of a module's blocking input port from a small
//             TX FIFO fed by a local valid/ready push interface. It also
//             consumes a module's blocking output port into a one-word RX
//             holding register that is drained through a local valid/ready
//             pop interface.
//  Options  : BLOCKING_PORT_PEER_TIMEOUT_EN enables the sticky TX stall
//             timeout (timeout_err). When it is undefined, timeout_err is
//             tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module blocking_port_peer #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  // local TX side
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  // module blocking input port
  output logic [DATA_W-1:0] in_data,
  output logic              in_sync,
  input  logic              in_notify,
  // module blocking output port
  input  logic [DATA_W-1:0] out_data,
  input  logic              out_notify,
  output logic              out_sync,
  // local RX side
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  input  logic              pop_ready,
  // status
  output logic [CNT_W-1:0]  tx_count,
  output logic [CNT_W-1:0]  rx_count,
  output logic              timeout_err
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]      OCC_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // RX FSM encoding
  localparam logic [0:0] RX_IDLE = 1'b0;
  localparam logic [0:0] RX_HOLD = 1'b1;

  // --------------------------------------------------------------------------
  // TX FIFO state
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       occupancy;

  logic fifo_full;
  logic fifo_empty;
  logic tx_push;
  logic tx_xfer;

  // FIFO status depends only on the registered occupancy, so neither
  // push_ready nor in_sync has a combinational path from push_valid.
  assign fifo_full  = (occupancy == FULL_CNT);
  assign fifo_empty = (occupancy == '0);
  assign push_ready = !fifo_full;
  assign in_sync    = !fifo_empty;
  assign in_data    = mem[rd_ptr];

  assign tx_push = push_valid && push_ready;
  assign tx_xfer = in_sync && in_notify;

  // Storage array; cleared on reset so that in_data reads 0 while empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (tx_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Write/read pointers wrap naturally modulo DEPTH (power of two).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (tx_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (tx_xfer) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Occupancy tracking. A simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occupancy <= '0;
    end else begin
      case ({tx_push, tx_xfer})
        2'b10:   occupancy <= occupancy + OCC_ONE;
        2'b01:   occupancy <= occupancy - OCC_ONE;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // RX path: two-state capture/hold FSM
  // --------------------------------------------------------------------------
  logic [0:0] rx_state;
  logic       rx_xfer;

  assign out_sync  = (rx_state == RX_IDLE);
  assign pop_valid = (rx_state == RX_HOLD);
  assign rx_xfer   = out_sync && out_notify;

  // Capture one word in IDLE, then hold it until the local side takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      pop_data <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_xfer) begin
            pop_data <= out_data;
            rx_state <= RX_HOLD;
          end
        end
        RX_HOLD: begin
          if (pop_ready) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Transfer counters (wrap silently)
  // --------------------------------------------------------------------------
  // Count completed transfers on the same edge that the transfer happens.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_count <= '0;
      rx_count <= '0;
    end else begin
      if (tx_xfer) tx_count <= tx_count + CNT_ONE;
      if (rx_xfer) rx_count <= rx_count + CNT_ONE;
    end
  end

  // --------------------------------------------------------------------------
  // Optional TX stall timeout
  // --------------------------------------------------------------------------
`ifdef BLOCKING_PORT_PEER_TIMEOUT_EN
  localparam int TW_RAW  = $clog2(TIMEOUT + 1);
  localparam int STALL_W = (TW_RAW > 8) ? TW_RAW : 8;
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT);
  localparam logic [STALL_W-1:0] STALL_ONE   = STALL_W'(1);

  logic [STALL_W-1:0] stall_cnt;
  logic               stalled;
  logic               err_flag;

  assign stalled     = in_sync && !in_notify;
  assign timeout_err = err_flag;

  // Count consecutive stall cycles, saturating at the limit. The error flag
  // is raised on the edge where the count reaches TIMEOUT and stays sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      err_flag  <= 1'b0;
    end else begin
      if (tx_xfer || fifo_empty) begin
        stall_cnt <= '0;
      end else if (stalled) begin
        if (stall_cnt != STALL_LIMIT) stall_cnt <= stall_cnt + STALL_ONE;
        if ((stall_cnt + STALL_ONE) >= STALL_LIMIT) err_flag <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/blocking_port_peer.md
Name: blocking_port_peer

Overview:
- Peer endpoint for the team's blocking-port handshake channels.
- Drives the consumer side of a module's blocking input port (data plus sync, waits on notify).
- Consumes a module's blocking output port (asserts sync, captures data on notify).
- Used as bench driver/monitor and as the glue partner when two generated modules are stitched together. Local side is plain valid/ready.

Parameters:
- DATA_W, 32, width of both channel payloads.
- DEPTH, 4, TX FIFO entries; power of 2, ≥2.
- CNT_W, 16, width of transfer counters.
- TIMEOUT, 255, stall-cycle limit (only with optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- push_valid  in  1  local TX request.
- push_data  in  DATA_W  local TX payload.
- push_ready  out  1  TX FIFO can accept.
- in_data  out  DATA_W  to module blocking input data.
- in_sync  out  1  to module input sync (data valid).
- in_notify  in  1  from module input notify (ready to read).
- out_data  in  DATA_W  from module blocking output data.
- out_notify  in  1  from module output notify (data valid).
- out_sync  out  1  to module output sync (ready to accept).
- pop_valid  out  1  RX word available.
- pop_data  out  DATA_W  RX payload.
- pop_ready  in  1  local consumer accepts.
- tx_count  out  CNT_W  completed TX transfers.
- rx_count  out  CNT_W  completed RX transfers.
- timeout_err  out  1  sticky stall error.

Behaviour:
- Transfer rule, both channels: a word moves on a rising clk where sync && notify are both 1. No other condition completes a transfer.
- Reset (rst=0, asynchronous):
  - FIFO empty; in_sync=0; in_data=0.
  - push_ready=1.
  - RX FSM in RX_IDLE; out_sync=1; pop_valid=0; pop_data=0.
  - Counters=0; timeout_err=0.
  - Reset mid-transfer discards all buffered data.
- TX path:
  - push accepted when push_valid && push_ready; push_ready = !full.
  - in_sync = !empty; in_data = FIFO head. Both are driven from registered state only, with no combinational path from push_*.
  - Latency: push into an empty FIFO shows on in_sync the next cycle.
  - in_sync=1 && in_notify=1 pops the head.
  - Push and pop in the same cycle: occupancy unchanged, data order preserved.
  - When full, push_ready=0 even if a pop occurs that cycle. There is no full-bypass.
  - Pointers wrap modulo DEPTH; occupancy tracked in a log2(DEPTH)+1-bit counter.
  - in_data stays stable while in_sync=1 and in_notify=0.
- RX path, two-state FSM:
  - RX_IDLE: out_sync=1, pop_valid=0. On out_sync && out_notify, capture out_data into pop_data and go to RX_HOLD.
  - RX_HOLD: out_sync=0, pop_valid=1. On pop_ready, go to RX_IDLE.
  - Peak throughput is one word per 2 cycles.
  - pop_data holds its value in RX_HOLD regardless of out_data.
  - out_notify while in RX_HOLD is ignored; no transfer occurs.
- Counters:
  - tx_count increments on each TX transfer; rx_count on each RX transfer.
  - Both wrap from 2^CNT_W-1 to 0 silently.
  - Update in the same edge as the transfer.

Optional Feature:
- Macro: BLOCKING_PORT_PEER_TIMEOUT_EN.
- Defined:
  - An 8+ bit stall counter increments each cycle with in_sync=1 && in_notify=0.
  - It clears on a TX transfer or when the FIFO is empty.
  - When it reaches TIMEOUT, timeout_err is set to 1. It stays 1 until reset.
  - Data flow is unaffected.
- Undefined: timeout_err is tied to 0 and no counter logic exists.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release → in_sync=0, out_sync=1, push_ready=1, pop_valid=0, counters 0.
- Back-to-back TX: push 0x11, 0x22, 0x33 with in_notify=1 held → in_data 0x11, 0x22, 0x33 on consecutive cycles starting one cycle after first push; tx_count=3.
- TX backpressure/full: in_notify=0, push 5 words with DEPTH=4 → push_ready=0 after the 4th. Then raise in_notify → words 1-4 emerge in order and the 5th push is accepted once not full.
- RX hold: out_notify=1 with out_data=0xCAFE, pop_ready=0 for 4 cycles → pop_data=0xCAFE, out_sync=0, rx_count=1. Change out_data to 0xBEEF → pop_data unchanged. pop_ready=1 → RX_IDLE next cycle.
- Counter wrap: preload by running 2^CNT_W TX transfers (CNT_W=4 build) → tx_count returns to 0 with no error.
- Timeout (macro on, TIMEOUT=10): one word pushed, in_notify=0 → timeout_err=1 after 10 stall cycles. Later transfer does not clear it; rst=0 clears it.
